// File: rtl/arb_pkg.sv
// Shared types for the 4-channel round-robin arbiter.
// Holds the channel count, select width and output slot states.
package arb_pkg;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;
endpackage

// File: rtl/rr_pick_4.sv
// Rotating priority search: first set request bit at or above ptr, modulo 4.
// Purely combinational.
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  sel_t            ptr,
    output logic            found,
    output sel_t            idx
);

    sel_t cand;

    // Walk from the farthest candidate back to ptr so the nearest set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = ptr + sel_t'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb_4.sv
// Four-channel round-robin arbiter with a single registered output slot.
// Grants move one word per cycle into the slot; ptr rotates past each winner.
module rr_arb_4
    import arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH-1:0][W-1:0] in_data,
    output logic [N_CH-1:0]        in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output sel_t                   out_sel
);

    slot_state_t state_q, state_d;
    sel_t        ptr_q;
    sel_t        gnt_idx;
    logic        found;
    logic        slot_free;
    logic        grant;

    rr_pick_4 u_pick (
        .req   (in_valid),
        .ptr   (ptr_q),
        .found (found),
        .idx   (gnt_idx)
    );

    assign out_valid = (state_q == FULL);

    // rst_n gates the handshake so nothing is accepted while reset is held.
    always_comb begin
        state_d   = state_q;
        in_ready  = '0;
        slot_free = (state_q == EMPTY) || out_ready;
        grant     = slot_free && found && rst_n;
        if (grant) begin
            in_ready[gnt_idx] = 1'b1;
        end
        if (slot_free) begin
            state_d = found ? FULL : EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_sel  <= '0;
            ptr_q    <= '0;
        end else if (grant) begin
            out_data <= in_data[gnt_idx];
            out_sel  <= gnt_idx;
            ptr_q    <= sel_t'(gnt_idx + 1'b1);
        end
    end

endmodule

// File: doc/rr_arb_4.md
RR_ARB_4 -- requirements
Module: rr_arb_4

Interface
REQ-001 Parameter: W, default 4, data width of every channel and of the output.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  4  per-channel request; bit i qualifies channel i.
REQ-005 Port: in_data  input  4xW  per-channel data; packed, channel i at slice [i].
REQ-006 Port: in_ready  output  4  per-channel acceptance; one-hot or zero.
REQ-007 Port: out_valid  output  1  output register holds a granted word.
REQ-008 Port: out_ready  input  1  downstream consumes the word when high with out_valid.
REQ-009 Port: out_data  output  W  data of the granted channel, registered.
REQ-010 Port: out_sel  output  2  index of the granted channel, registered; drives downstream 4:1 selectors.

Function
REQ-011 Transfer occurs on an input channel i when in_valid[i] and in_ready[i] are both high at a rising clk edge; the same rule applies on the output with out_valid/out_ready.
REQ-012 Output stage: one register slot (out_valid, out_data, out_sel); two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 Slot is "free" in a cycle when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-014 Grant: when free and any in_valid bit is set, exactly one channel g is granted: the first set bit searching from ptr upward, modulo 4.
REQ-015 in_ready[g]=1 combinationally for the granted channel only; all in_ready bits are 0 when the slot is not free or no in_valid bit is set.
REQ-016 On grant: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= (g+1) mod 4; latency of exactly one cycle from input transfer to out_valid.
REQ-017 Wrap-around: a grant of channel 3 sets ptr to 0.
REQ-018 Slot free and no in_valid bit set: out_valid <= 0; out_data, out_sel and ptr hold.
REQ-019 FULL and out_ready=0: out_valid, out_data, out_sel and ptr hold, and all in_ready bits are 0.
REQ-020 Simultaneous output consume and new grant in one cycle: slot stays FULL with the new word; sustains one word per cycle.
REQ-021 in_valid deasserted before grant: the request is dropped with no state change; the arbiter does not remember pending requests.
REQ-022 Fairness: with all four channels continuously valid and out_ready=1, grants cycle in the order 0,1,2,3,0,...
REQ-023 No combinational path from in_data to any output; in_ready depends combinationally on in_valid, out_valid, out_ready and ptr.

Reset
REQ-024 While rst_n=0: out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready=0 regardless of other inputs.
REQ-025 Reset asserted mid-transfer discards the held word immediately (out_valid falls without waiting for clk).
REQ-026 First grant after rst_n release uses ptr=0: channel 0 has highest priority.

Structure
REQ-027 Shared package arb_pkg holds N_CH=4, SEL_W=2 and typedef sel_t (logic [SEL_W-1:0]); used for out_sel and ptr.
REQ-028 Priority search is a combinational sub-module rr_pick_4 (inputs: 4-bit request, 2-bit pointer; outputs: found flag, 2-bit index).
REQ-029 Top level contains only the pointer register, the output slot and the handshake logic.

Verification
REQ-030 Reset: rst_n low with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
REQ-031 Single channel: in_valid=4'b0100, in_data[2]=4'hA, out_ready=1 -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_sel=2, out_data=4'hA.
REQ-032 Round-robin: in_valid=4'b1111 held, data[i]=i+1, out_ready=1 for 6 cycles -> out_sel sequence 0,1,2,3,0,1 and out_data 1,2,3,4,1,2, out_valid=1 every cycle.
REQ-033 Backpressure: slot FULL with out_sel=1, out_ready=0 for 3 cycles while in_valid=4'b1111 -> in_ready=0, out_data/out_sel unchanged; on out_ready=1 the next word is channel 2.
REQ-034 Skip and wrap: ptr=3, in_valid=4'b0010 -> channel 1 granted, ptr becomes 2; then in_valid=4'b1001 -> channel 3 granted, ptr wraps to 0.
REQ-035 Mid-operation reset: rst_n pulsed low while out_valid=1 -> out_valid drops before the next edge; after release with in_valid=4'b1010, channel 1 is granted first.
